mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage. Aligns/extends load return data and holds
//            the writeback register. MEM_ALIGN_CHECK_EN adds alignment checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_flush_i,
  input  logic        mem_stall_i,
  input  logic        mem_wren_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_nofwd_i,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_inslot_i,
  input  logic [31:0] mem_pc_i,
  input  logic [7:0]  mem_memop_i,
  input  logic        mem_inst_load_i,
  input  logic [1:0]  mem_memaddr_low_i,
  input  logic [31:0] data_sram_rdata_i,
  input  logic        data_sram_rvalid_i,
  output logic        mem_stallreq_o,
  output logic [31:0] mem_wdata_bp_o,
  output logic        mem_nofwd_bp_o,
  output logic        wb_wren_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] wb_inst_o,
  output logic        wb_inslot_o,
  output logic [31:0] wb_pc_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        mem_addr_err_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        wb_wren_q, wb_wren_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic        wb_inslot_q, wb_inslot_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic        addr_err_q, addr_err_d;

  logic        addr_err;
  logic        misalign_ld;
  logic        load;
  logic        stallreq;
  logic        use_buf;
  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] next_wdata;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = ((mem_memop_i[2] | mem_memop_i[3] | mem_memop_i[6]) & mem_memaddr_low_i[0])
                  | ((mem_memop_i[4] | mem_memop_i[7]) & (mem_memaddr_low_i != 2'b00));
`else
  logic unused_memop;
  assign unused_memop = ^mem_memop_i[7:5];
  assign addr_err     = 1'b0;
`endif

  // A misaligned load never reaches memory, so it must not wait for a response.
  assign misalign_ld = addr_err & mem_inst_load_i;
  assign load        = mem_inst_load_i & ~misalign_ld;

  always_comb begin
    state_d  = state_q;
    rbuf_d   = rbuf_q;
    stallreq = 1'b0;
    use_buf  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load && !mem_flush_i) begin
          if (data_sram_rvalid_i) begin
            if (mem_stall_i) begin
              rbuf_d  = data_sram_rdata_i;
              state_d = S_HOLD;
            end
          end else begin
            stallreq = 1'b1;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_flush_i) begin
          state_d = data_sram_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (data_sram_rvalid_i) begin
          if (mem_stall_i) begin
            rbuf_d  = data_sram_rdata_i;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          stallreq = 1'b1;
        end
      end
      S_HOLD: begin
        use_buf = 1'b1;
        if (mem_flush_i) begin
          rbuf_d  = 32'h0;
          state_d = S_IDLE;
        end else if (!mem_stall_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The response in flight belongs to the killed load and is dropped.
        stallreq = load;
        if (data_sram_rvalid_i) begin
          state_d = (load && !mem_flush_i) ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_src  = use_buf ? rbuf_q : data_sram_rdata_i;
    ld_byte = 8'h0;
    ld_half = 16'h0;
    ld_data = 32'h0;
    case (mem_memaddr_low_i)
      2'd0:    ld_byte = ld_src[7:0];
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    ld_half = mem_memaddr_low_i[1] ? ld_src[31:16] : ld_src[15:0];
    if (mem_memop_i[0])      ld_data = {{24{ld_byte[7]}}, ld_byte};
    else if (mem_memop_i[1]) ld_data = {24'h0, ld_byte};
    else if (mem_memop_i[2]) ld_data = {{16{ld_half[15]}}, ld_half};
    else if (mem_memop_i[3]) ld_data = {16'h0, ld_half};
    else                     ld_data = ld_src;
    next_wdata = load ? ld_data : mem_wdata_i;
  end

  always_comb begin
    wb_wren_d   = 1'b0;
    wb_waddr_d  = 5'h0;
    wb_wdata_d  = 32'h0;
    wb_inst_d   = 32'h0;
    wb_inslot_d = 1'b0;
    wb_pc_d     = 32'h0;
    addr_err_d  = 1'b0;
    if (!mem_flush_i && !stallreq) begin
      wb_wren_d   = mem_wren_i & ~misalign_ld;
      wb_waddr_d  = mem_waddr_i;
      wb_wdata_d  = next_wdata;
      wb_inst_d   = mem_inst_i;
      wb_inslot_d = mem_inslot_i;
      wb_pc_d     = mem_pc_i;
      addr_err_d  = addr_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rbuf_q      <= 32'h0;
      wb_wren_q   <= 1'b0;
      wb_waddr_q  <= 5'h0;
      wb_wdata_q  <= 32'h0;
      wb_inst_q   <= 32'h0;
      wb_inslot_q <= 1'b0;
      wb_pc_q     <= 32'h0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      if (!mem_stall_i) begin
        wb_wren_q   <= wb_wren_d;
        wb_waddr_q  <= wb_waddr_d;
        wb_wdata_q  <= wb_wdata_d;
        wb_inst_q   <= wb_inst_d;
        wb_inslot_q <= wb_inslot_d;
        wb_pc_q     <= wb_pc_d;
        addr_err_q  <= addr_err_d;
      end
    end
  end

  assign mem_stallreq_o = stallreq;
  assign mem_wdata_bp_o = next_wdata;
  assign mem_nofwd_bp_o = mem_nofwd_i | (load & stallreq);
  assign wb_wren_o      = wb_wren_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign wb_inst_o      = wb_inst_q;
  assign wb_inslot_o    = wb_inslot_q;
  assign wb_pc_o        = wb_pc_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_addr_err_o = addr_err_q;
`else
  logic unused_err;
  assign unused_err = addr_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed vector and sequence checks for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush_i, mem_stall_i, mem_wren_i, mem_nofwd_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i, mem_inst_i, mem_pc_i;
  logic        mem_inslot_i;
  logic [7:0]  mem_memop_i;
  logic        mem_inst_load_i;
  logic [1:0]  mem_memaddr_low_i;
  logic [31:0] data_sram_rdata_i;
  logic        data_sram_rvalid_i;
  logic        mem_stallreq_o, mem_nofwd_bp_o;
  logic [31:0] mem_wdata_bp_o;
  logic        wb_wren_o, wb_inslot_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o, wb_inst_o, wb_pc_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_addr_err_o;
`endif

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .mem_flush_i        (mem_flush_i),
    .mem_stall_i        (mem_stall_i),
    .mem_wren_i         (mem_wren_i),
    .mem_waddr_i        (mem_waddr_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_nofwd_i        (mem_nofwd_i),
    .mem_inst_i         (mem_inst_i),
    .mem_inslot_i       (mem_inslot_i),
    .mem_pc_i           (mem_pc_i),
    .mem_memop_i        (mem_memop_i),
    .mem_inst_load_i    (mem_inst_load_i),
    .mem_memaddr_low_i  (mem_memaddr_low_i),
    .data_sram_rdata_i  (data_sram_rdata_i),
    .data_sram_rvalid_i (data_sram_rvalid_i),
    .mem_stallreq_o     (mem_stallreq_o),
    .mem_wdata_bp_o     (mem_wdata_bp_o),
    .mem_nofwd_bp_o     (mem_nofwd_bp_o),
    .wb_wren_o          (wb_wren_o),
    .wb_waddr_o         (wb_waddr_o),
    .wb_wdata_o         (wb_wdata_o),
    .wb_inst_o          (wb_inst_o),
    .wb_inslot_o        (wb_inslot_o),
    .wb_pc_o            (wb_pc_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_addr_err_o     (mem_addr_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  memop;
    logic        ld;
    logic [1:0]  al;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    rst = 1'b0; mem_flush_i = 1'b0; mem_stall_i = 1'b0; mem_wren_i = 1'b0;
    mem_nofwd_i = 1'b0; mem_waddr_i = 5'h0; mem_wdata_i = 32'h0; mem_inst_i = 32'h0;
    mem_inslot_i = 1'b0; mem_pc_i = 32'h0; mem_memop_i = 8'h0; mem_inst_load_i = 1'b0;
    mem_memaddr_low_i = 2'd0; data_sram_rdata_i = 32'h0; data_sram_rvalid_i = 1'b0;
  endtask

  task automatic set_load(input logic [7:0] op, input logic [1:0] al, input logic [31:0] pc);
    mem_memop_i = op; mem_inst_load_i = 1'b1; mem_memaddr_low_i = al;
    mem_wren_i = 1'b1; mem_waddr_i = 5'd7; mem_pc_i = pc; mem_inst_i = 32'h8C00_0000 | pc;
  endtask

  initial begin
    vt[0] = '{8'h01, 1'b1, 2'd2, 32'h12803456, 32'h0,        1'b1, 32'hFFFFFF80};
    vt[1] = '{8'h02, 1'b1, 2'd2, 32'h12803456, 32'h0,        1'b1, 32'h00000080};
    vt[2] = '{8'h01, 1'b1, 2'd0, 32'h12803456, 32'h0,        1'b1, 32'h00000056};
    vt[3] = '{8'h01, 1'b1, 2'd3, 32'h92000000, 32'h0,        1'b1, 32'hFFFFFF92};
    vt[4] = '{8'h04, 1'b1, 2'd0, 32'h1234F00D, 32'h0,        1'b1, 32'hFFFFF00D};
    vt[5] = '{8'h08, 1'b1, 2'd2, 32'h80010000, 32'h0,        1'b1, 32'h00008001};
    vt[6] = '{8'h04, 1'b1, 2'd2, 32'h7FFF0000, 32'h0,        1'b1, 32'h00007FFF};
    vt[7] = '{8'h10, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[8] = '{8'h00, 1'b0, 2'd0, 32'h0,        32'h11223344, 1'b1, 32'h11223344};
    vt[9] = '{8'h80, 1'b0, 2'd0, 32'h55555555, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE};

    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_wren",  {31'h0, wb_wren_o}, 32'h0);
    chk("reset_wdata", wb_wdata_o, 32'h0);
    chk("reset_pc",    wb_pc_o, 32'h0);
    chk("reset_stallreq", {31'h0, mem_stallreq_o}, 32'h0);

    // Single-cycle vectors: loads with same-cycle response and non-loads.
    for (int i = 0; i < 10; i++) begin
      idle_in();
      mem_memop_i = vt[i].memop; mem_inst_load_i = vt[i].ld; mem_memaddr_low_i = vt[i].al;
      data_sram_rdata_i = vt[i].rdata; data_sram_rvalid_i = vt[i].ld;
      mem_wdata_i = vt[i].wdata; mem_wren_i = vt[i].wren; mem_waddr_i = 5'(i + 1);
      mem_pc_i = 32'h1000 + 32'(i * 4); mem_inst_i = 32'hA000_0000 | 32'(i);
      #1;
      chk($sformatf("v%0d_stallreq", i), {31'h0, mem_stallreq_o}, 32'h0);
      chk($sformatf("v%0d_bp", i), mem_wdata_bp_o, vt[i].exp);
      tick();
      chk($sformatf("v%0d_wdata", i), wb_wdata_o, vt[i].exp);
      chk($sformatf("v%0d_wren", i), {31'h0, wb_wren_o}, {31'h0, vt[i].wren});
      chk($sformatf("v%0d_pc", i), wb_pc_o, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_waddr", i), {27'h0, wb_waddr_o}, 32'(i + 1));
    end

    // Flush in IDLE produces a bubble.
    idle_in();
    mem_wren_i = 1'b1; mem_wdata_i = 32'h77; mem_pc_i = 32'h40; mem_flush_i = 1'b1;
    tick();
    chk("flush_idle_wren", {31'h0, wb_wren_o}, 32'h0);
    chk("flush_idle_pc", wb_pc_o, 32'h0);

    // lhu with response three cycles late.
    idle_in();
    set_load(8'h08, 2'd2, 32'h2000);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lhu_stallreq%0d", c), {31'h0, mem_stallreq_o}, 32'h1);
      chk($sformatf("lhu_nofwd%0d", c), {31'h0, mem_nofwd_bp_o}, 32'h1);
      tick();
      chk($sformatf("lhu_bubble%0d", c), {31'h0, wb_wren_o}, 32'h0);
    end
    data_sram_rvalid_i = 1'b1; data_sram_rdata_i = 32'h80010000;
    #1;
    chk("lhu_stallreq_done", {31'h0, mem_stallreq_o}, 32'h0);
    tick();
    chk("lhu_wdata", wb_wdata_o, 32'h00008001);
    chk("lhu_wren", {31'h0, wb_wren_o}, 32'h1);
    chk("lhu_pc", wb_pc_o, 32'h2000);

    // lw: response arrives under stall, held in the buffer until release.
    idle_in();
    set_load(8'h10, 2'd0, 32'h3000);
    tick();
    mem_stall_i = 1'b1; data_sram_rvalid_i = 1'b1; data_sram_rdata_i = 32'h13572468;
    tick();
    data_sram_rvalid_i = 1'b0; data_sram_rdata_i = 32'hFFFFFFFF;
    #1;
    chk("hold_stallreq", {31'h0, mem_stallreq_o}, 32'h0);
    chk("hold_bp", mem_wdata_bp_o, 32'h13572468);
    tick();
    chk("hold_wb_held", {31'h0, wb_wren_o}, 32'h0);
    mem_stall_i = 1'b0;
    tick();
    chk("hold_wdata", wb_wdata_o, 32'h13572468);
    chk("hold_pc", wb_pc_o, 32'h3000);

    // Flush in WAIT, new load, stale response then real response.
    idle_in();
    set_load(8'h10, 2'd0, 32'h4000);
    tick();
    mem_flush_i = 1'b1;
    tick();
    mem_flush_i = 1'b0;
    set_load(8'h10, 2'd0, 32'h4004);
    #1;
    chk("drain_stallreq", {31'h0, mem_stallreq_o}, 32'h1);
    tick();
    data_sram_rvalid_i = 1'b1; data_sram_rdata_i = 32'hDEAD0000;
    #1;
    chk("drain_stale_stallreq", {31'h0, mem_stallreq_o}, 32'h1);
    tick();
    chk("drain_stale_dropped", {31'h0, wb_wren_o}, 32'h0);
    data_sram_rdata_i = 32'hA5A5A5A5;
    #1;
    chk("drain_real_stallreq", {31'h0, mem_stallreq_o}, 32'h0);
    tick();
    chk("drain_wdata", wb_wdata_o, 32'hA5A5A5A5);
    chk("drain_pc", wb_pc_o, 32'h4004);

    // Reset while waiting: wb registers cleared and state back to IDLE.
    idle_in();
    mem_wren_i = 1'b1; mem_wdata_i = 32'h99; mem_pc_i = 32'h5000; mem_inst_i = 32'h1;
    tick();
    set_load(8'h10, 2'd0, 32'h5004);
    mem_stall_i = 1'b1;
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wait_wren", {31'h0, wb_wren_o}, 32'h0);
    chk("rst_wait_wdata", wb_wdata_o, 32'h0);
    chk("rst_wait_pc", wb_pc_o, 32'h0);
    chk("rst_wait_inst", wb_inst_o, 32'h0);
    chk("rst_wait_idle", {31'h0, mem_stallreq_o}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    idle_in();
    set_load(8'h10, 2'd1, 32'h6000);
    #1;
    chk("align_stallreq", {31'h0, mem_stallreq_o}, 32'h0);
    tick();
    chk("align_err", {31'h0, mem_addr_err_o}, 32'h1);
    chk("align_wren", {31'h0, wb_wren_o}, 32'h0);
    idle_in();
    set_load(8'h10, 2'd0, 32'h6004);
    data_sram_rvalid_i = 1'b1; data_sram_rdata_i = 32'h1;
    tick();
    chk("align_ok_err", {31'h0, mem_addr_err_o}, 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
